// File: rtl/lcd_frame_arbiter.sv
// rtl/lcd_frame_arbiter.sv - frame-granular round-robin arbiter in front of the SPI LCD chunk port
// Owner keeps the port for a whole frame; a stall watchdog reclaims it from a silent producer.
module lcd_frame_arbiter #(
   parameter logic [31:0] CHUNKS_PER_FRAME = 32'd10,
   parameter logic [31:0] TIMEOUT          = 32'd1000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic [255:0] data0,
   input  logic         valid0,
   output logic         ready0,
   input  logic         req1,
   input  logic [255:0] data1,
   input  logic         valid1,
   output logic         ready1,
   output logic [1:0]   grant,
   output logic [255:0] buffer,
   output logic         bufferDA,
   input  logic         bufferRtR,
   output logic         frame_done,
   output logic         abort
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [1:0]  grant_nxt;
   logic        last, last_nxt;
   logic [31:0] chunk_cnt, chunk_cnt_nxt;
   logic [31:0] stall_cnt, stall_cnt_nxt;
   logic        frame_done_nxt, abort_nxt;
   logic        owner_valid;
   logic        beat;
   logic        stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= 2'b00;
         last       <= 1'b1;
         chunk_cnt  <= 32'd0;
         stall_cnt  <= 32'd0;
         frame_done <= 1'b0;
         abort      <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last       <= last_nxt;
         chunk_cnt  <= chunk_cnt_nxt;
         stall_cnt  <= stall_cnt_nxt;
         frame_done <= frame_done_nxt;
         abort      <= abort_nxt;
      end
   end

   assign beat  = bufferDA && bufferRtR;
   // Only a ready screen with nothing to take counts as a stall; a busy screen freezes the watchdog.
   assign stall = (state == XFER) && bufferRtR && !owner_valid;

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_nxt       = last;
      chunk_cnt_nxt  = chunk_cnt;
      stall_cnt_nxt  = stall_cnt;
      frame_done_nxt = 1'b0;
      abort_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt     = XFER;
               chunk_cnt_nxt = 32'd0;
               stall_cnt_nxt = 32'd0;
               if (req0 && req1)
                  grant_nxt = last ? 2'b01 : 2'b10;
               else
                  grant_nxt = req0 ? 2'b01 : 2'b10;
            end
         end
         XFER: begin
            if (beat) begin
               stall_cnt_nxt = 32'd0;
               if (chunk_cnt == CHUNKS_PER_FRAME - 32'd1) begin
                  frame_done_nxt = 1'b1;
                  last_nxt       = grant[1];
                  grant_nxt      = 2'b00;
                  chunk_cnt_nxt  = 32'd0;
                  state_nxt      = IDLE;
               end else begin
                  chunk_cnt_nxt = chunk_cnt + 32'd1;
               end
            end else if (stall) begin
               if (stall_cnt == TIMEOUT - 32'd1) begin
                  abort_nxt     = 1'b1;
                  last_nxt      = grant[1];
                  grant_nxt     = 2'b00;
                  stall_cnt_nxt = 32'd0;
                  state_nxt     = IDLE;
               end else begin
                  stall_cnt_nxt = stall_cnt + 32'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      buffer      = '0;
      owner_valid = 1'b0;
      if (grant[0]) begin
         buffer      = data0;
         owner_valid = valid0;
      end else if (grant[1]) begin
         buffer      = data1;
         owner_valid = valid1;
      end
      bufferDA = owner_valid && (state == XFER);
      ready0   = bufferRtR && grant[0];
      ready1   = bufferRtR && grant[1];
   end

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// tb/tb_lcd_frame_arbiter.sv - self-checking bench for lcd_frame_arbiter
// Integer-level frame model checked every cycle, plus directed scenario expectations.
module tb_lcd_frame_arbiter;

   localparam int CPF = 10;
   localparam int TO  = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0, req1, valid0, valid1, bufferRtR;
   logic [255:0] data0, data1;
   logic         ready0, ready1, bufferDA, frame_done, abort;
   logic [1:0]   grant;
   logic [255:0] buffer;

   lcd_frame_arbiter #(.CHUNKS_PER_FRAME(32'd10), .TIMEOUT(32'd5)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .data0(data0), .valid0(valid0), .ready0(ready0),
      .req1(req1), .data1(data1), .valid1(valid1), .ready1(ready1),
      .grant(grant), .buffer(buffer), .bufferDA(bufferDA), .bufferRtR(bufferRtR),
      .frame_done(frame_done), .abort(abort)
   );

   always #5 clk = ~clk;

   // Model: owner -1 means nobody holds the port.
   int   m_owner, m_sent, m_run, m_prev;
   logic m_done, m_abort, m_v;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_owner = -1; m_sent = 0; m_run = 0; m_prev = 1; m_done = 0; m_abort = 0;
      end else begin
         m_done = 0; m_abort = 0;
         if (m_owner < 0) begin
            if (req0 && req1) m_owner = 1 - m_prev;
            else if (req0)    m_owner = 0;
            else if (req1)    m_owner = 1;
            m_sent = 0; m_run = 0;
         end else begin
            m_v = (m_owner == 0) ? valid0 : valid1;
            if (m_v && bufferRtR) begin
               m_sent++; m_run = 0;
               if (m_sent == CPF) begin m_done = 1; m_prev = m_owner; m_owner = -1; end
            end else if (bufferRtR) begin
               m_run++;
               if (m_run == TO) begin m_abort = 1; m_prev = m_owner; m_owner = -1; end
            end
         end
      end
   end

   int n_checks = 0, n_fail = 0, cyc = 0;
   int beats = 0, gcyc = 0, dones = 0, aborts = 0;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step;
      logic [255:0] eb;
      logic         ev;
      logic [1:0]   eg;
      @(negedge clk);
      eb = '0; ev = 1'b0; eg = 2'b00;
      if (m_owner == 0) begin eb = data0; ev = valid0; eg = 2'b01; end
      else if (m_owner == 1) begin eb = data1; ev = valid1; eg = 2'b10; end
      check("grant", grant, eg);
      check("frame_done", frame_done, m_done);
      check("abort", abort, m_abort);
      check("buffer", buffer, eb);
      check("bufferDA", bufferDA, ev);
      check("ready0", ready0, bufferRtR && m_owner == 0);
      check("ready1", ready1, bufferRtR && m_owner == 1);
      if (bufferDA && bufferRtR) beats++;
      if (grant != 2'b00) gcyc++;
      if (frame_done) dones++;
      if (abort) aborts++;
      @(posedge clk);
      #1;
      cyc++;
      data0 = {8{32'hA000_0000 + 32'(cyc)}};
      data1 = {8{32'hB000_0000 + 32'(cyc)}};
   endtask

   task automatic wait_for(input bit want_abort, input int bound, output int n);
      bit seen;
      seen = 0; n = 0;
      while (!seen && n < bound) begin
         step;
         n++;
         seen = want_abort ? abort : frame_done;
      end
      check(want_abort ? "abort_seen" : "done_seen", seen, 1);
   endtask

   task automatic do_reset;
      reset = 1; req0 = 0; req1 = 0; valid0 = 0; valid1 = 0; bufferRtR = 0;
      step; step;
      reset = 0;
   endtask

   initial begin
      int n, b0, g0, a0;
      data0 = '0; data1 = '0;
      do_reset;
      check("rst_grant", grant, 2'b00);
      check("rst_done", frame_done, 0);
      check("rst_abort", abort, 0);
      check("rst_da", bufferDA, 0);

      // Single producer, full frame
      req0 = 1; valid0 = 1; bufferRtR = 1;
      b0 = beats; g0 = gcyc;
      step; check("t1_grant", grant, 2'b01);
      req0 = 0;
      wait_for(0, 40, n);
      check("t1_len", n, 10);
      check("t1_grant_end", grant, 2'b00);
      check("t1_beats", beats - b0, 10);
      check("t1_gcyc", gcyc - g0, 10);

      // Round robin across three frames
      do_reset;
      req0 = 1; req1 = 1; valid0 = 1; valid1 = 1; bufferRtR = 1;
      step; check("t2_f0", grant, 2'b01);
      wait_for(0, 40, n); check("t2_gap0", grant, 2'b00);
      step; check("t2_f1", grant, 2'b10);
      wait_for(0, 40, n); check("t2_gap1", grant, 2'b00);
      step; check("t2_f2", grant, 2'b01);
      req0 = 0; req1 = 0;
      wait_for(0, 40, n);

      // Screen ready every other cycle
      do_reset;
      req0 = 1; valid0 = 1; bufferRtR = 1;
      a0 = aborts; g0 = gcyc;
      step; check("t3_grant", grant, 2'b01);
      req0 = 0; bufferRtR = 0;
      n = 0;
      while (!frame_done && n < 60) begin
         step; n++;
         if (!frame_done) bufferRtR = ~bufferRtR;
      end
      check("t3_done", frame_done, 1);
      check("t3_gcyc", gcyc - g0, 20);
      check("t3_no_abort", aborts - a0, 0);
      bufferRtR = 1;

      // Watchdog abort, waiting producer 0 takes over
      do_reset;
      req1 = 1; valid1 = 1; bufferRtR = 1;
      step; check("t4_grant", grant, 2'b10);
      req0 = 1; valid0 = 1;
      b0 = beats;
      step; step; step;
      valid1 = 0;
      check("t4_beats", beats - b0, 3);
      wait_for(1, 20, n);
      check("t4_abort_lat", n, 5);
      check("t4_grant_abort", grant, 2'b00);
      step; check("t4_next", grant, 2'b01);
      req0 = 0; req1 = 0; valid1 = 1;
      wait_for(0, 40, n);

      // Request dropped mid-frame keeps ownership
      do_reset;
      req1 = 1; valid1 = 1; bufferRtR = 1;
      g0 = gcyc;
      step; check("t5_grant", grant, 2'b10);
      step; step;
      req1 = 0;
      wait_for(0, 40, n);
      check("t5_gcyc", gcyc - g0, 10);
      step; check("t5_idle", grant, 2'b00);

      // Asynchronous reset mid-frame
      do_reset;
      req1 = 1; valid1 = 1; bufferRtR = 1;
      step; check("t6_grant", grant, 2'b10);
      b0 = beats;
      step; step; step; step;
      check("t6_beats", beats - b0, 4);
      #2 reset = 1;
      #1;
      check("t6_async_grant", grant, 2'b00);
      check("t6_async_da", bufferDA, 0);
      check("t6_async_rdy", ready1, 0);
      req0 = 1; req1 = 1; valid0 = 1;
      step; step;
      reset = 0;
      b0 = beats;
      step; check("t6_tie", grant, 2'b01);
      req0 = 0; req1 = 0;
      wait_for(0, 40, n);
      check("t6_len", n, 10);
      check("t6_beats_new", beats - b0, 10);
      step;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_frame_arbiter.md
# lcd_frame_arbiter

Shares the single 256-bit chunk port of the SPI LCD `screen` driver between two frame producers. The block grants the port to one requester for a whole frame of `CHUNKS_PER_FRAME` chunks and forwards that requester's chunks over the `buffer`/`bufferDA`/`bufferRtR` handshake. Ownership alternates round-robin between frames. A stall watchdog reclaims the port from a producer that stops supplying data. It sits between the pixel sources (pattern/LFSR generator, text overlay) and `screen`.

## Interface
Parameters:
- `CHUNKS_PER_FRAME`, default 32'd10: 256-bit chunks per frame; must be ≥ 1.
- `TIMEOUT`, default 32'd1000: consecutive owner-stall cycles before abort; must be ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`  in  1  producer 0 requests a frame slot.
- `data0`  in  256  producer 0 chunk.
- `valid0`  in  1  `data0` valid.
- `ready0`  out  1  chunk 0 accepted this cycle.
- `req1`, `data1`, `valid1`, `ready1`: same as above, for producer 1.
- `grant`  out  2  one-hot current owner; 2'b00 when idle.
- `buffer`  out  256  chunk to `screen`.
- `bufferDA`  out  1  `buffer` valid.
- `bufferRtR`  in  1  `screen` ready to receive.
- `frame_done`  out  1  one-cycle pulse: frame completed.
- `abort`  out  1  one-cycle pulse: frame abandoned by watchdog.

## Operation
- The FSM has two states, IDLE and XFER. Registered: state, `grant`, `last` (previous owner), `chunk_cnt` (32b), `stall_cnt` (32b), `frame_done`, `abort`.
- A beat is a cycle with `bufferDA && bufferRtR`.
- Combinational datapath, mux selected by `grant`:
  - `buffer` = owner data.
  - `bufferDA` = owner valid AND XFER.
  - `readyN` = `bufferRtR` AND `grant[N]`.
  - Idle: `buffer` = 0, `bufferDA` = 0, `ready0` = `ready1` = 0.
- IDLE:
  - No req: stay IDLE.
  - One req: grant that producer.
  - Both req: grant the producer that is not `last`.
  - On grant: go to XFER, `chunk_cnt` = 0, `stall_cnt` = 0.
- XFER:
  - Each beat: `chunk_cnt`++, `stall_cnt` = 0.
  - Beat with `chunk_cnt == CHUNKS_PER_FRAME-1`: `frame_done` pulse, `last` = owner, `grant` = 0, go to IDLE.
  - Cycle with `bufferRtR`=1 and owner valid=0: `stall_cnt`++.
  - `stall_cnt == TIMEOUT-1` on such a cycle: `abort` pulse, `last` = owner, `grant` = 0, go to IDLE. Partial frame discarded; no chunks are replayed.
  - `bufferRtR`=0 (screen busy): `stall_cnt` holds. A slow screen never triggers abort.
  - `req` is ignored in XFER: dropping it mid-frame does not release the port.
- A final beat and a watchdog expiry cannot coincide, because a beat clears the stall condition. The beat takes effect.
- Reset, asynchronous, any state: IDLE, `grant`=0, `last`=1 (producer 0 wins the first tie), counters 0, `frame_done`=0, `abort`=0. A frame in flight is dropped.

## Timing
- `req` is sampled in IDLE. `grant` rises on the next edge, and the first beat can occur in that same grant cycle.
- Frame without stalls: `grant` high exactly `CHUNKS_PER_FRAME` cycles.
- The edge after the last beat:
  - `grant` = 0 and `frame_done` = 1 for one cycle.
  - The earliest next grant is one cycle later.
- Minimum gap between frames: 1 IDLE cycle.
- Abort: `abort` = 1 and `grant` = 0 on the edge after the TIMEOUT-th consecutive stall cycle.
- `readyN` and `bufferDA` have zero latency (combinational) relative to `bufferRtR`/`validN`.

## Test plan
- Reset, then only `req0` with `valid0`=1 and `bufferRtR`=1, CHUNKS=10:
  - `grant`=01 one cycle after req.
  - 10 consecutive beats.
  - `frame_done` pulse with `grant`=00.
  - `buffer` sequence equals `data0` sequence.
- `req0` and `req1` held high for 3 frames: grants go 01, 10, 01, each separated by one IDLE cycle.
- `bufferRtR` toggling every cycle, TIMEOUT=5, owner always valid:
  - 20 cycles to complete 10 chunks.
  - No abort.
  - `ready0` mirrors `bufferRtR`.
- Owner drops `valid1` after 3 beats while `bufferRtR`=1, TIMEOUT=5:
  - `abort` pulse 5 cycles after the last beat.
  - `grant`=00.
  - A waiting `req0` is granted next.
- `req1` deasserted mid-frame: `grant` stays 10 until all 10 chunks are sent.
- `reset` asserted mid-frame after 4 beats:
  - Outputs clear immediately and asynchronously.
  - After release, a tied request grants producer 0.
  - The new frame counts from 0.
